hdmi_config_sequencer: RTL and testbench
========================================

# hdmi_config_sequencer

Walks a table of 16-bit {register, value} words and issues them one at a time to the downstream I2C write controller, which configures the HDMI transmitter after power-up. For each entry it presents the slave address and register word, pulses `i2c_start` and waits for the controller's end-of-transfer indication. On a NACK or timeout it retries the same entry, and it flags an error when retries are exhausted. It sits directly upstream of the I2C controller, and the table lives in an external synchronous ROM.

## Interface
Parameters:
- `NUM_REGS`, 32: number of table entries, 1..255.
- `SLAVE_ADDRESS`, 8'h72: 8-bit bus address presented on `slave_address`.
- `POWER_UP_DELAY`, 20000: cycles to wait after reset before the first transfer, ≥1.
- `GAP_CYCLES`, 4: idle cycles between transfers, ≥1.
- `TIMEOUT_CYCLES`, 1000: maximum cycles to wait for `i2c_done`.
- `RETRY_LIMIT`, 3: attempts per entry before error, ≥1.

Ports:
- `clock` in 1: single clock; same clock as the I2C controller.
- `reset` in 1: synchronous, active-high.
- `restart` in 1: one-cycle pulse; re-runs the table from entry 0.
- `rom_address` out 8: table index.
- `rom_data` in 16: table word; valid one cycle after `rom_address`. {reg[15:8], value[7:0]}.
- `i2c_done` in 1: controller transfer complete; driven by the controller's `stop`.
- `i2c_nack` in 1: controller acknowledge failure; driven by the controller's `ack`. Sampled when `i2c_done`=1.
- `i2c_start` out 1: one-cycle start pulse to the controller.
- `register_data` out 16: word being written; stable from `i2c_start` until the next fetch.
- `slave_address` out 8: constant `SLAVE_ADDRESS` after reset.
- `busy` out 1: sequence in progress.
- `config_done` out 1: all entries written successfully.
- `config_error` out 1: an entry failed `RETRY_LIMIT` times.
- `error_count` out 8: total NACKs and timeouts, saturating at 255.

## Operation
Reset values:
- All outputs 0 except `slave_address`, which is `SLAVE_ADDRESS`.
- Index, retry counter and delay counter are 0. State is POWER_WAIT.

States:
- **POWER_WAIT**: `busy`=1. Count `POWER_UP_DELAY` cycles, then go to FETCH with index 0.
- **FETCH**: drive `rom_address`=index for one cycle, then go to LATCH.
- **LATCH**: capture `rom_data` into `register_data`.
  - If `rom_data`==16'hFFFF (end marker), go to DONE.
  - Otherwise go to ISSUE.
- **ISSUE**: `i2c_start`=1 for exactly this cycle. Clear the timeout counter. Go to WAIT.
- **WAIT**: hold until `i2c_done`=1 or the timeout counter reaches `TIMEOUT_CYCLES`.
  - Success (done with `i2c_nack`=0): index+1, retry counter cleared. If index+1 == `NUM_REGS`, go to DONE; else go to GAP, then FETCH.
  - Failure (done with `i2c_nack`=1, or timeout): `error_count`+1 (saturating), retry+1. If retry+1 == `RETRY_LIMIT`, go to ERROR; else go to GAP, then ISSUE (same `register_data`, no refetch).
- **GAP**: `GAP_CYCLES` idle cycles, `i2c_start`=0.
- **DONE**: `config_done`=1, `busy`=0. Hold until `restart`.
- **ERROR**: `config_error`=1, `busy`=0. `rom_address` holds the failing index. Hold until `restart`.

`restart` rules:
- Honoured only in DONE or ERROR. It clears `config_done`, `config_error` and the index, then goes to FETCH, skipping POWER_WAIT. `error_count` is kept.
- Ignored in all other states.

## Timing
- `restart` in DONE → FETCH next cycle → LATCH → `i2c_start` high on the 3rd cycle after `restart`.
- `i2c_done` received → GAP starts next cycle → `GAP_CYCLES` later, FETCH. The next `i2c_start` comes `GAP_CYCLES`+3 cycles after `i2c_done` on success, and `GAP_CYCLES`+1 on retry.
- `i2c_done` in the same cycle the timeout expires: treat as done; `i2c_nack` decides the outcome.
- `i2c_done` or `i2c_nack` outside WAIT: ignored.
- `i2c_start` is never high in two consecutive cycles and never high outside ISSUE.
- `reset` mid-transfer: next edge gives reset values and POWER_WAIT. The controller is not aborted; it finishes its own sequence, and any `i2c_done` it raises during POWER_WAIT is ignored.
- `NUM_REGS`=1: a single transfer, then DONE.

## Test plan
- **Basic run**: `POWER_UP_DELAY`=10, ROM = {16'h4110, 16'h9803, 16'hFFFF}, controller model returns ack. Expect `i2c_start` exactly twice with `register_data` 16'h4110 then 16'h9803, then `config_done`=1, `busy`=0, `error_count`=0.
- **NACK then success**: first attempt at entry 0 NACKs. Expect a second `i2c_start` `GAP_CYCLES`+1 cycles after `i2c_done` with the same `register_data`, then entry 1 fetched; `error_count`=1.
- **Retry exhaustion**: entry 2 always NACKs, `RETRY_LIMIT`=3. Expect 3 starts, then `config_error`=1, `rom_address`=2, `error_count`=3, and no further starts.
- **Timeout**: `i2c_done` never asserted, `TIMEOUT_CYCLES`=50. Expect a retry start 50+`GAP_CYCLES`+1 cycles after the previous start; `error_count` increments each time.
- **Restart and reset**: `restart` pulsed in DONE gives `i2c_start` 3 cycles later with index 0. `restart` pulsed mid-WAIT has no effect. `reset` asserted mid-WAIT gives all outputs at reset values on the next cycle, then a full POWER_WAIT.
- **Saturation**: force 300 failures across restarts. Expect `error_count` holds at 255.

Source files
------------

// File: rtl/hdmi_config_sequencer.sv
// Walks a {register, value} table held in an external synchronous ROM and issues each
// entry to the downstream I2C write controller, retrying failed transfers up to a limit.
module hdmi_config_sequencer #(
  parameter int          NUM_REGS       = 32,
  parameter logic [7:0]  SLAVE_ADDRESS  = 8'h72,
  parameter int          POWER_UP_DELAY = 20000,
  parameter int          GAP_CYCLES     = 4,
  parameter int          TIMEOUT_CYCLES = 1000,
  parameter int          RETRY_LIMIT    = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        restart,
  output logic [7:0]  rom_address,
  input  logic [15:0] rom_data,
  input  logic        i2c_done,
  input  logic        i2c_nack,
  output logic        i2c_start,
  output logic [15:0] register_data,
  output logic [7:0]  slave_address,
  output logic        busy,
  output logic        config_done,
  output logic        config_error,
  output logic [7:0]  error_count
);

  localparam logic [31:0] POWER_LAST   = 32'(POWER_UP_DELAY - 1);
  localparam logic [31:0] GAP_LAST     = 32'(GAP_CYCLES - 1);
  localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]  RETRY_LAST   = 8'(RETRY_LIMIT - 1);
  localparam logic [7:0]  INDEX_LAST   = 8'(NUM_REGS - 1);

  typedef enum logic [2:0] {
    S_POWER_WAIT,
    S_FETCH,
    S_LATCH,
    S_ISSUE,
    S_WAIT,
    S_GAP,
    S_DONE,
    S_ERROR
  } state_t;

  state_t      state, state_next;
  logic [31:0] count, count_next;
  logic [7:0]  index, index_next;
  logic [7:0]  retry, retry_next;
  logic        retry_pending, retry_pending_next;
  logic [7:0]  error_count_next;
  logic [15:0] register_data_next;
  logic        busy_next;

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= S_POWER_WAIT;
      count         <= '0;
      index         <= '0;
      retry         <= '0;
      retry_pending <= 1'b0;
      error_count   <= '0;
      register_data <= '0;
      busy          <= 1'b0;
    end else begin
      state         <= state_next;
      count         <= count_next;
      index         <= index_next;
      retry         <= retry_next;
      retry_pending <= retry_pending_next;
      error_count   <= error_count_next;
      register_data <= register_data_next;
      busy          <= busy_next;
    end
  end

  // One shared counter serves the power-up delay, the inter-transfer gap and the timeout.
  always_comb begin
    state_next         = state;
    count_next         = count;
    index_next         = index;
    retry_next         = retry;
    retry_pending_next = retry_pending;
    error_count_next   = error_count;
    register_data_next = register_data;
    case (state)
      S_POWER_WAIT: begin
        if (count == POWER_LAST) begin
          state_next = S_FETCH;
          count_next = '0;
          index_next = '0;
        end else begin
          count_next = count + 32'd1;
        end
      end
      S_FETCH: state_next = S_LATCH;
      S_LATCH: begin
        register_data_next = rom_data;
        state_next         = (rom_data == 16'hFFFF) ? S_DONE : S_ISSUE;
      end
      S_ISSUE: begin
        count_next = '0;
        state_next = S_WAIT;
      end
      S_WAIT: begin
        // A done arriving on the timeout cycle wins; the nack flag decides the outcome.
        if (i2c_done || (count == TIMEOUT_LAST)) begin
          count_next = '0;
          if (i2c_done && !i2c_nack) begin
            index_next         = index + 8'd1;
            retry_next         = '0;
            retry_pending_next = 1'b0;
            state_next         = (index == INDEX_LAST) ? S_DONE : S_GAP;
          end else begin
            if (error_count != 8'hFF) error_count_next = error_count + 8'd1;
            if (retry == RETRY_LAST) begin
              retry_next = '0;
              state_next = S_ERROR;
            end else begin
              retry_next         = retry + 8'd1;
              retry_pending_next = 1'b1;
              state_next         = S_GAP;
            end
          end
        end else begin
          count_next = count + 32'd1;
        end
      end
      S_GAP: begin
        if (count == GAP_LAST) begin
          count_next         = '0;
          retry_pending_next = 1'b0;
          state_next         = retry_pending ? S_ISSUE : S_FETCH;
        end else begin
          count_next = count + 32'd1;
        end
      end
      S_DONE, S_ERROR: begin
        if (restart) begin
          index_next         = '0;
          retry_next         = '0;
          retry_pending_next = 1'b0;
          count_next         = '0;
          state_next         = S_FETCH;
        end
      end
      default: state_next = S_POWER_WAIT;
    endcase
  end

  always_comb begin
    busy_next = (state_next != S_DONE) && (state_next != S_ERROR);
  end

  // On error the index still points at the failing entry, so rom_address reports it.
  assign rom_address   = index;
  assign i2c_start     = (state == S_ISSUE);
  assign config_done   = (state == S_DONE);
  assign config_error  = (state == S_ERROR);
  assign slave_address = SLAVE_ADDRESS;

endmodule

// File: tb/tb_hdmi_config_sequencer.sv
// Directed bench for hdmi_config_sequencer: ROM model, hand-driven I2C controller responses.
module tb_hdmi_config_sequencer;

  logic        clock, reset, reset1, restart;
  logic [7:0]  rom_address, rom_address1;
  logic [15:0] rom_data, rom_data1;
  logic        i2c_done, i2c_nack, i2c_start;
  logic        i2c_done1, i2c_nack1, i2c_start1;
  logic [15:0] register_data, register_data1;
  logic [7:0]  slave_address, slave_address1;
  logic        busy, config_done, config_error;
  logic        busy1, config_done1, config_error1;
  logic [7:0]  error_count, error_count1;

  logic [15:0] rom [0:255];
  int n_cmp = 0;
  int n_err = 0;
  int n, c;

  hdmi_config_sequencer #(
    .NUM_REGS(32), .SLAVE_ADDRESS(8'h72), .POWER_UP_DELAY(10),
    .GAP_CYCLES(4), .TIMEOUT_CYCLES(50), .RETRY_LIMIT(3)
  ) dut (
    .clock(clock), .reset(reset), .restart(restart),
    .rom_address(rom_address), .rom_data(rom_data),
    .i2c_done(i2c_done), .i2c_nack(i2c_nack), .i2c_start(i2c_start),
    .register_data(register_data), .slave_address(slave_address),
    .busy(busy), .config_done(config_done), .config_error(config_error),
    .error_count(error_count)
  );

  hdmi_config_sequencer #(
    .NUM_REGS(1), .SLAVE_ADDRESS(8'h72), .POWER_UP_DELAY(10),
    .GAP_CYCLES(4), .TIMEOUT_CYCLES(50), .RETRY_LIMIT(3)
  ) dut_one (
    .clock(clock), .reset(reset1), .restart(1'b0),
    .rom_address(rom_address1), .rom_data(rom_data1),
    .i2c_done(i2c_done1), .i2c_nack(i2c_nack1), .i2c_start(i2c_start1),
    .register_data(register_data1), .slave_address(slave_address1),
    .busy(busy1), .config_done(config_done1), .config_error(config_error1),
    .error_count(error_count1)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) begin
    rom_data  <= rom[rom_address];
    rom_data1 <= rom[rom_address1];
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_start(input int limit, output int steps);
    steps = 0;
    while (i2c_start !== 1'b1 && steps < limit) begin
      step();
      steps++;
    end
    check("start_seen", 32'(i2c_start), 1);
  endtask

  task automatic wait_flag(input logic is_error, input int limit, output int steps);
    steps = 0;
    while ((is_error ? config_error : config_done) !== 1'b1 && steps < limit) begin
      step();
      steps++;
    end
    check("flag_seen", 32'(is_error ? config_error : config_done), 1);
  endtask

  // Called while i2c_start is high; raises i2c_done after 'delay' cycles in WAIT.
  task automatic respond(input logic nack, input int delay);
    step();
    check("start_single", 32'(i2c_start), 0);
    for (int k = 1; k < delay; k++) step();
    i2c_done = 1'b1;
    i2c_nack = nack;
    step();
    i2c_done = 1'b0;
    i2c_nack = 1'b0;
  endtask

  task automatic pulse_restart();
    restart = 1'b1;
    step();
    restart = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 16'hFFFF;
    rom[0] = 16'h4110;
    rom[1] = 16'h9803;
    reset = 1'b1; reset1 = 1'b1; restart = 1'b0;
    i2c_done = 1'b0; i2c_nack = 1'b0; i2c_done1 = 1'b0; i2c_nack1 = 1'b0;
    step(); step();
    check("rst_start", 32'(i2c_start), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(config_done), 0);
    check("rst_error", 32'(config_error), 0);
    check("rst_errcnt", 32'(error_count), 0);
    check("rst_romaddr", 32'(rom_address), 0);
    check("rst_regdata", 32'(register_data), 0);
    check("rst_slave", 32'(slave_address), 32'h72);
    reset = 1'b0;
    step();
    check("busy_power_wait", 32'(busy), 1);
    wait_start(50, n);
    check("power_latency", n, 11);
    check("basic_reg0", 32'(register_data), 32'h4110);
    check("basic_addr0", 32'(rom_address), 0);
    respond(1'b0, 2);
    wait_start(50, n);
    check("basic_gap", n, 6);
    check("basic_reg1", 32'(register_data), 32'h9803);
    respond(1'b0, 3);
    wait_flag(1'b0, 50, n);
    check("basic_done_lat", n, 6);
    check("basic_busy", 32'(busy), 0);
    check("basic_errcnt", 32'(error_count), 0);
    c = 0;
    repeat (20) begin step(); if (i2c_start) c++; end
    check("done_no_start", c, 0);

    pulse_restart();
    wait_start(50, n);
    check("restart_lat", n, 2);
    check("restart_reg", 32'(register_data), 32'h4110);
    check("restart_addr", 32'(rom_address), 0);
    respond(1'b1, 2);
    wait_start(50, n);
    check("retry_gap", n, 4);
    check("retry_reg", 32'(register_data), 32'h4110);
    check("retry_errcnt", 32'(error_count), 1);
    step();
    pulse_restart();
    check("restart_in_wait_busy", 32'(busy), 1);
    i2c_done = 1'b1;
    step();
    i2c_done = 1'b0;
    wait_start(50, n);
    check("wait_restart_ignored", n, 6);
    check("next_entry_reg", 32'(register_data), 32'h9803);
    check("next_entry_addr", 32'(rom_address), 1);
    respond(1'b0, 1);
    wait_flag(1'b0, 50, n);
    check("nack_run_errcnt", 32'(error_count), 1);

    rom[2] = 16'h2233;
    rom[3] = 16'hFFFF;
    pulse_restart();
    wait_start(50, n); respond(1'b0, 1);
    wait_start(50, n); respond(1'b0, 1);
    wait_start(50, n);
    check("exh_reg", 32'(register_data), 32'h2233);
    respond(1'b1, 1);
    wait_start(50, n);
    check("exh_gap", n, 4);
    respond(1'b1, 1);
    wait_start(50, n); respond(1'b1, 1);
    wait_flag(1'b1, 50, n);
    check("exh_err_lat", n, 0);
    check("exh_addr", 32'(rom_address), 2);
    check("exh_errcnt", 32'(error_count), 4);
    check("exh_busy", 32'(busy), 0);
    c = 0;
    repeat (30) begin step(); if (i2c_start) c++; end
    check("error_no_start", c, 0);

    pulse_restart();
    wait_start(50, n);
    step();
    wait_start(100, n);
    check("timeout_lat1", n, 54);
    check("timeout_reg", 32'(register_data), 32'h4110);
    check("timeout_errcnt1", 32'(error_count), 5);
    step();
    wait_start(100, n);
    check("timeout_lat2", n, 54);
    check("timeout_errcnt2", 32'(error_count), 6);
    wait_flag(1'b1, 100, n);
    check("timeout_err_lat", n, 51);
    check("timeout_errcnt3", 32'(error_count), 7);
    check("timeout_addr", 32'(rom_address), 0);

    pulse_restart();
    wait_start(50, n);
    respond(1'b0, 50);
    wait_start(50, n);
    check("done_at_timeout_gap", n, 6);
    check("done_at_timeout_reg", 32'(register_data), 32'h9803);
    check("done_at_timeout_cnt", 32'(error_count), 7);
    respond(1'b0, 1);
    wait_start(50, n); respond(1'b0, 1);
    wait_flag(1'b0, 50, n);

    pulse_restart();
    wait_start(50, n);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("midrst_start", 32'(i2c_start), 0);
    check("midrst_busy", 32'(busy), 0);
    check("midrst_done", 32'(config_done), 0);
    check("midrst_error", 32'(config_error), 0);
    check("midrst_errcnt", 32'(error_count), 0);
    check("midrst_regdata", 32'(register_data), 0);
    check("midrst_romaddr", 32'(rom_address), 0);
    step(); step(); step();
    i2c_done = 1'b1; i2c_nack = 1'b1;
    step();
    i2c_done = 1'b0; i2c_nack = 1'b0;
    wait_start(50, n);
    check("midrst_power_lat", n, 8);
    check("midrst_done_ignored", 32'(error_count), 0);
    check("midrst_reg", 32'(register_data), 32'h4110);
    respond(1'b0, 1);
    wait_start(50, n); respond(1'b0, 1);
    wait_start(50, n); respond(1'b0, 1);
    wait_flag(1'b0, 50, n);

    for (int i = 0; i < 100; i++) begin
      pulse_restart();
      repeat (3) begin
        wait_start(50, n);
        respond(1'b1, 1);
      end
      wait_flag(1'b1, 50, n);
      if (i == 83) check("sat_252", 32'(error_count), 252);
    end
    check("sat_255", 32'(error_count), 255);

    reset1 = 1'b0;
    n = 0;
    while (i2c_start1 !== 1'b1 && n < 50) begin
      step();
      n++;
    end
    check("one_power_lat", n, 12);
    check("one_reg", 32'(register_data1), 32'h4110);
    step();
    i2c_done1 = 1'b1;
    step();
    i2c_done1 = 1'b0;
    check("one_done", 32'(config_done1), 1);
    check("one_busy", 32'(busy1), 0);
    check("one_errcnt", 32'(error_count1), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
